// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-N-1 UART transmitter, one byte per valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even parity bit (8-E-1).

module uart_tx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_ready,
  output logic       o_uart_tx,
  output logic       o_tx_done
);

  localparam int MCNT_BAUD = CLOCK_FREQ / BAUD_RATE - 1;
  localparam int CNT_W     = (MCNT_BAUD > 0) ? $clog2(MCNT_BAUD + 1) : 1;
  localparam logic [CNT_W-1:0] MCNT = CNT_W'(MCNT_BAUD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             bit_end;

  assign bit_end = (baud_cnt == MCNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'd0;
      o_uart_tx <= 1'b1;
      o_ready   <= 1'b1;
      o_tx_done <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt  <= '0;
          o_uart_tx <= 1'b1;
          o_ready   <= 1'b1;
          if (i_data_valid && o_ready) begin
            shift_reg <= i_data;
            bit_idx   <= 3'd0;
            state     <= START;
            o_ready   <= 1'b0;
            o_uart_tx <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            state     <= DATA;
            o_uart_tx <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
              state     <= PARITY;
              o_uart_tx <= ^shift_reg;
`else
              state     <= STOP;
              o_uart_tx <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              o_uart_tx <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            state     <= STOP;
            o_uart_tx <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            state     <= IDLE;
            o_ready   <= 1'b1;
            o_tx_done <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        // Unreachable encodings recover to a quiet, ready line.
        default: begin
          state     <= IDLE;
          baud_cnt  <= '0;
          bit_idx   <= 3'd0;
          o_uart_tx <= 1'b1;
          o_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed table-driven bench for uart_tx at 10 clocks per bit.

module tb_uart_tx;

  localparam int BPER = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 10;
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_data = 8'd0;
  logic       i_data_valid = 1'b0;
  logic       o_ready;
  logic       o_uart_tx;
  logic       o_tx_done;

  uart_tx #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_ready(o_ready), .o_uart_tx(o_uart_tx), .o_tx_done(o_tx_done)
  );

  always #5 clk = ~clk;

  // Frames listed in line order: start, d0..d7, then stop/stop (8N1) or parity/stop (8E1).
  typedef struct {
    logic [7:0]  data;
    logic [0:10] fn;
    logic [0:10] fp;
  } vec_t;

  vec_t tbl[6];
  logic ln[0:399];
  logic rd[0:399];
  logic dn[0:399];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Samples #1 after each of n edges; hooks alter stimulus right after the sample at edge k.
  task automatic capture(input int n, input int chg_k, input logic [7:0] chg_d,
                         input int drop_k, input int pulse_k);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      ln[k] = o_uart_tx;
      rd[k] = o_ready;
      dn[k] = o_tx_done;
      if (k == chg_k) i_data = chg_d;
      if (k == drop_k) i_data_valid = 1'b0;
      if (k == pulse_k) i_data_valid = 1'b1;
      if (pulse_k != 0 && k == pulse_k + 1) i_data_valid = 1'b0;
    end
  endtask

  task automatic check_frame(input int base, input logic [0:10] fr, input string nm);
    int m;
    int last;
    last = base + NB * BPER;
    for (int p = 0; p < NB; p++) begin
      m = 0;
      for (int s = 0; s < BPER; s++)
        if (ln[base + p * BPER + s] === fr[p]) m++;
      chk($sformatf("%s bit%0d samples", nm, p), m, BPER);
    end
    m = 0;
    for (int k = base; k < last; k++) if (rd[k] === 1'b0) m++;
    chk({nm, " ready low"}, m, NB * BPER);
    m = 0;
    for (int k = base; k < last; k++) if (dn[k] !== 1'b0) m++;
    chk({nm, " done early"}, m, 0);
    chk({nm, " done pulse"}, dn[last], 1);
    chk({nm, " ready back"}, rd[last], 1);
  endtask

  task automatic send_table(input vec_t v, input string nm);
    int m;
    @(posedge clk);
    #1;
    i_data = v.data;
    i_data_valid = 1'b1;
    capture(NB * BPER + 11, 0, 8'd0, 1, 0);
    check_frame(1, PAR ? v.fp : v.fn, nm);
    m = 0;
    for (int k = NB * BPER + 2; k <= NB * BPER + 11; k++)
      if (ln[k] === 1'b1 && rd[k] === 1'b1 && dn[k] === 1'b0) m++;
    chk({nm, " idle after"}, m, 10);
  endtask

  initial begin
    int m;
    vec_t v;
    tbl[0] = '{8'h55, 11'b0_10101010_1_1, 11'b0_10101010_0_1};
    tbl[1] = '{8'hA3, 11'b0_11000101_1_1, 11'b0_11000101_0_1};
    tbl[2] = '{8'h00, 11'b0_00000000_1_1, 11'b0_00000000_0_1};
    tbl[3] = '{8'hFF, 11'b0_11111111_1_1, 11'b0_11111111_0_1};
    tbl[4] = '{8'h81, 11'b0_10000001_1_1, 11'b0_10000001_0_1};
    tbl[5] = '{8'h01, 11'b0_10000000_1_1, 11'b0_10000000_1_1};

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset line", o_uart_tx, 1);
    chk("reset ready", o_ready, 1);
    chk("reset done", o_tx_done, 0);
    rst_n = 1'b1;
    capture(50, 0, 8'd0, 0, 0);
    m = 0;
    for (int k = 1; k <= 50; k++)
      if (ln[k] === 1'b1 && rd[k] === 1'b1 && dn[k] === 1'b0) m++;
    chk("idle 50 clocks", m, 50);

    for (int i = 0; i < 6; i++)
      send_table(tbl[i], $sformatf("tbl%0d", i));

    // Back-to-back with valid held: 0x00 then 0xFF
    @(posedge clk);
    #1;
    i_data = 8'h00;
    i_data_valid = 1'b1;
    capture(2 * NB * BPER + 12, 1, 8'hFF, NB * BPER + 2, 0);
    check_frame(1, PAR ? tbl[2].fp : tbl[2].fn, "b2b first");
    chk("b2b stop extended", ln[NB * BPER + 1], 1);
    chk("b2b second start", ln[NB * BPER + 2], 0);
    chk("b2b ready low", rd[NB * BPER + 2], 0);
    check_frame(NB * BPER + 2, PAR ? tbl[3].fp : tbl[3].fn, "b2b second");

    // 0x0F with i_data and a valid pulse disturbed mid-frame
    @(posedge clk);
    #1;
    i_data = 8'h0F;
    i_data_valid = 1'b1;
    capture(NB * BPER + 40, 35, 8'hF0, 1, 35);
    check_frame(1, PAR ? 11'b0_11110000_0_1 : 11'b0_11110000_1_1, "chg");
    m = 0;
    for (int k = 1; k <= NB * BPER + 40; k++) if (dn[k] === 1'b1) m++;
    chk("chg one done", m, 1);
    m = 0;
    for (int k = NB * BPER + 2; k <= NB * BPER + 40; k++)
      if (ln[k] === 1'b1 && rd[k] === 1'b1) m++;
    chk("chg no second frame", m, 39);

    // Reset during data bit 3 of 0x81
    @(posedge clk);
    #1;
    i_data = 8'h81;
    i_data_valid = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) i_data_valid = 1'b0;
    end
    chk("mid bit3 line", o_uart_tx, 0);
    rst_n = 1'b0;
    #1;
    chk("async rst line", o_uart_tx, 1);
    chk("async rst ready", o_ready, 1);
    chk("async rst done", o_tx_done, 0);
    capture(3, 0, 8'd0, 0, 0);
    rst_n = 1'b1;
    capture(20, 0, 8'd0, 0, 0);
    m = 0;
    for (int k = 1; k <= 20; k++)
      if (ln[k] === 1'b1 && rd[k] === 1'b1 && dn[k] === 1'b0) m++;
    chk("post rst quiet", m, 20);
    v = tbl[4];
    send_table(v, "post rst 0x81");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
